// File: rtl/sys_bus_decoder.sv
// One-master, N-slave system bus decoder: routes each access to a 2^RAW-byte
// region, answers unmapped/malformed requests itself and bounds slave latency.
module sys_bus_decoder #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int SW  = DW / 8,
    parameter int N   = 8,
    parameter int RAW = 20,
    parameter int CW  = (N > 1) ? $clog2(N) : 1,
    parameter int TMO = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_wen,
    input  logic            m_ren,
    input  logic [AW-1:0]   m_addr,
    input  logic [SW-1:0]   m_sel,
    input  logic [DW-1:0]   m_wdata,
    output logic [DW-1:0]   m_rdata,
    output logic            m_ack,
    output logic            m_err,
    output logic [N-1:0]    s_wen,
    output logic [N-1:0]    s_ren,
    output logic [AW-1:0]   s_addr,
    output logic [SW-1:0]   s_sel,
    output logic [DW-1:0]   s_wdata,
    input  logic [N*DW-1:0] s_rdata,
    input  logic [N-1:0]    s_ack,
    input  logic [N-1:0]    s_err,
    output logic [1:0]      dbg_state
);

    // Handshake: a master strobe is accepted only in IDLE; every accepted
    // access gets exactly one m_ack pulse with m_rdata/m_err valid alongside.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [AW-1:0] low_mask(input int nbits);
        logic [AW-1:0] m;
        for (int i = 0; i < AW; i++) m[i] = (i < nbits);
        return m;
    endfunction

    localparam logic [AW-1:0] REGION_MASK = low_mask(RAW);
    localparam logic [AW-1:0] HIGH_MASK   = ~low_mask(RAW + CW);
    localparam logic [CW:0]   N_EXT       = (CW + 1)'(N);
    localparam logic [15:0]   TMO_LAST    = 16'(TMO - 1);

    state_t          state;
    logic [CW-1:0]   idx;
    logic            is_write;
    logic [15:0]     cnt;
    logic [CW-1:0]   req_idx;
    logic            req_bad;
    logic [DW-1:0]   sel_rdata;

    assign dbg_state = state;
    assign req_idx   = m_addr[RAW +: CW];
    assign req_bad   = (m_wen & m_ren)
                     | ({1'b0, req_idx} >= N_EXT)
                     | (|(m_addr & HIGH_MASK));
    assign sel_rdata = s_rdata[idx * DW +: DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            is_write <= 1'b0;
            cnt      <= '0;
            m_rdata  <= '0;
            m_ack    <= 1'b0;
            m_err    <= 1'b0;
            s_wen    <= '0;
            s_ren    <= '0;
            s_addr   <= '0;
            s_sel    <= '0;
            s_wdata  <= '0;
        end else begin
            s_wen <= '0;
            s_ren <= '0;
            case (state)
                IDLE: begin
                    if (m_wen | m_ren) begin
                        if (req_bad) begin
                            m_rdata <= '0;
                            m_err   <= 1'b1;
                            m_ack   <= 1'b1;
                            state   <= RESP;
                        end else begin
                            idx            <= req_idx;
                            is_write       <= m_wen;
                            s_addr         <= m_addr & REGION_MASK;
                            s_sel          <= m_sel;
                            s_wdata        <= m_wdata;
                            s_wen[req_idx] <= m_wen;
                            s_ren[req_idx] <= m_ren;
                            cnt            <= '0;
                            state          <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 16'd1;
                    // An ack in the final budget cycle still wins over the timeout.
                    if (s_ack[idx]) begin
                        m_rdata <= is_write ? '0 : sel_rdata;
                        m_err   <= s_err[idx];
                        m_ack   <= 1'b1;
                        state   <= RESP;
                    end else if (cnt == TMO_LAST) begin
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        m_ack   <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    m_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_decoder.sv
// Directed bench for sys_bus_decoder (N=8, RAW=20, TMO=16): routing, errors,
// timeout, isolation of unselected slaves and mid-transaction reset.
module tb_sys_bus_decoder;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int N   = 8;
    localparam int RAW = 20;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_wen, m_ren;
    logic [AW-1:0]   m_addr;
    logic [SW-1:0]   m_sel;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_ack, m_err;
    logic [N-1:0]    s_wen, s_ren;
    logic [AW-1:0]   s_addr;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_wdata;
    logic [N*DW-1:0] s_rdata;
    logic [N-1:0]    s_ack, s_err;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    sys_bus_decoder #(
        .DW(DW), .AW(AW), .SW(SW), .N(N), .RAW(RAW), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_wen(m_wen), .m_ren(m_ren), .m_addr(m_addr), .m_sel(m_sel),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_wen(s_wen), .s_ren(s_ren), .s_addr(s_addr), .s_sel(s_sel),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Drive a request for one edge; returns at the negedge of cycle T0+1.
    task automatic issue(input logic wen, input logic ren, input logic [AW-1:0] addr,
                         input logic [SW-1:0] sel, input logic [DW-1:0] wdata);
        m_wen   = wen;
        m_ren   = ren;
        m_addr  = addr;
        m_sel   = sel;
        m_wdata = wdata;
        tick();
        m_wen = 1'b0;
        m_ren = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_m_ack"},   m_ack,   0);
        chk({tag, "_m_err"},   m_err,   0);
        chk({tag, "_m_rdata"}, m_rdata, 0);
        chk({tag, "_s_wen"},   s_wen,   0);
        chk({tag, "_s_ren"},   s_ren,   0);
        chk({tag, "_s_addr"},  s_addr,  0);
        chk({tag, "_s_sel"},   s_sel,   0);
        chk({tag, "_s_wdata"}, s_wdata, 0);
        chk({tag, "_state"},   dbg_state, 0);
    endtask

    initial begin
        rst = 1'b1; m_wen = 0; m_ren = 0; m_addr = '0; m_sel = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0; s_err = '0;
        repeat (3) tick();
        chk_reset_values("rst");
        rst = 1'b0;
        tick();

        // Write to slave 3, same-cycle ack.
        issue(1, 0, 32'h0030_0010, 4'hF, 32'hDEAD_BEEF);
        chk("wr_s_wen",   s_wen,   8'b0000_1000);
        chk("wr_s_ren",   s_ren,   0);
        chk("wr_s_addr",  s_addr,  32'h10);
        chk("wr_s_sel",   s_sel,   4'hF);
        chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("wr_ack_early", m_ack, 0);
        s_ack[3] = 1'b1;
        tick();
        s_ack[3] = 1'b0;
        chk("wr_ack",     m_ack,   1);
        chk("wr_err",     m_err,   0);
        chk("wr_rdata",   m_rdata, 0);
        chk("wr_strobe_once", s_wen, 0);
        tick();
        chk("wr_ack_one", m_ack,   0);

        // Read from slave 5, ack 4 cycles after strobe with err.
        for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = 32'hA0A0_0000 + i;
        s_rdata[5*DW +: DW] = 32'h1234_5678;
        issue(0, 1, 32'h0050_0004, 4'h3, 32'h0);
        chk("rd_s_ren",  s_ren,  8'b0010_0000);
        chk("rd_s_addr", s_addr, 32'h4);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("rd_wait%0d", k), m_ack, 0);
        end
        s_ack[5] = 1'b1; s_err[5] = 1'b1;
        tick();
        s_ack[5] = 1'b0; s_err[5] = 1'b0;
        chk("rd_ack",   m_ack,   1);
        chk("rd_rdata", m_rdata, 32'h1234_5678);
        chk("rd_err",   m_err,   1);
        tick();
        chk("rd_ack_one",    m_ack,   0);
        chk("rd_rdata_hold", m_rdata, 32'h1234_5678);

        // Slave 2 never acks: timeout, then a late ack is ignored.
        issue(0, 1, 32'h0020_0000, 4'hF, 32'h0);
        chk("to_s_ren", s_ren, 8'b0000_0100);
        for (int k = 2; k <= 22; k++) begin
            if (k == 20) s_ack[2] = 1'b1;
            if (k == 21) s_ack[2] = 1'b0;
            tick();
            chk($sformatf("to_ack_c%0d", k), m_ack, (k == TMO + 1) ? 1 : 0);
            if (k == TMO + 1) begin
                chk("to_err",   m_err,   1);
                chk("to_rdata", m_rdata, 0);
            end
        end
        s_ack = '0;

        // Unmapped and malformed accesses, all answered at T0+1.
        issue(0, 1, 32'h0100_0000, 4'hF, 32'h0);
        chk("bad_hi_ack",  m_ack, 1);
        chk("bad_hi_err",  m_err, 1);
        chk("bad_hi_strb", {s_wen, s_ren}, 0);
        tick();
        chk("bad_hi_ack_one", m_ack, 0);
        issue(0, 1, 32'h0080_0000, 4'hF, 32'h0);
        chk("bad_b23_ack",  m_ack, 1);
        chk("bad_b23_err",  m_err, 1);
        chk("bad_b23_strb", {s_wen, s_ren}, 0);
        tick();
        issue(1, 1, 32'h0010_0000, 4'hF, 32'h1);
        chk("bad_rw_ack",   m_ack,   1);
        chk("bad_rw_err",   m_err,   1);
        chk("bad_rw_rdata", m_rdata, 0);
        chk("bad_rw_strb",  {s_wen, s_ren}, 0);
        tick();

        // Slave 1 selected: dropped strobe, foreign ack ignored.
        issue(0, 1, 32'h0010_0008, 4'hF, 32'h0);
        chk("iso_s_ren", s_ren, 8'b0000_0010);
        m_wen = 1'b1; m_addr = 32'h0060_0000; m_wdata = 32'h7777_7777;
        tick();
        m_wen = 1'b0;
        s_ack[4] = 1'b1; s_err[4] = 1'b1;
        chk("iso_drop_strb", s_wen, 0);
        tick();
        s_ack[4] = 1'b0; s_err[4] = 1'b0;
        chk("iso_drop_addr", s_addr, 32'h8);
        chk("iso_ack4_ign",  m_ack,  0);
        s_rdata[1*DW +: DW] = 32'hCAFE_0001;
        s_ack[1] = 1'b1;
        tick();
        s_ack[1] = 1'b0;
        chk("iso_ack",   m_ack,   1);
        chk("iso_err",   m_err,   0);
        chk("iso_rdata", m_rdata, 32'hCAFE_0001);
        m_ren = 1'b1; m_addr = 32'h0030_0000;
        tick();
        m_ren = 1'b0;
        chk("resp_drop_strb", s_ren, 0);
        chk("resp_ack_low",   m_ack, 0);
        tick();
        chk("resp_drop_noack", m_ack, 0);

        // Reset while BUSY; a concurrent ack must not leak a response.
        issue(1, 0, 32'h0070_00FC, 4'h3, 32'h0000_55AA);
        chk("rb_s_wen", s_wen, 8'b1000_0000);
        rst = 1'b1; s_ack[7] = 1'b1;
        tick();
        rst = 1'b0; s_ack[7] = 1'b0;
        chk_reset_values("rb");
        tick();
        chk("rb_noack", m_ack, 0);
        issue(1, 0, 32'h0000_0004, 4'h1, 32'h0000_00A5);
        chk("rb2_s_wen",   s_wen,   8'b0000_0001);
        chk("rb2_s_wdata", s_wdata, 32'h0000_00A5);
        tick();
        s_ack[0] = 1'b1;
        tick();
        s_ack[0] = 1'b0;
        chk("rb2_ack", m_ack, 1);
        chk("rb2_err", m_err, 0);
        tick();
        chk("rb2_ack_one", m_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
